// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for the burst master.
//   HTRANS_*   transfer type codes
//   HBURST_*   supported burst codes (SINGLE, INCR4/8/16)
//   HRESP_*    slave response codes
//   state_t    master FSM encoding
//   burst_beats() maps a burst code to its beat count; 0 marks an unsupported code
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_BURST,
    S_LAST,
    S_ERR
  } state_t;

  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    case (burst)
      HBURST_SINGLE: return 5'd1;
      HBURST_INCR4:  return 5'd4;
      HBURST_INCR8:  return 5'd8;
      HBURST_INCR16: return 5'd16;
      default:       return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// ahb_addr_gen: beat address/counter generator and command legality check.
//   hclk, hresetn   clock, async active-low reset
//   load            capture cmd_addr/cmd_size/cmd_burst at command acceptance
//   step            an address phase completed: advance address, count a beat
//   cmd_*           command fields, checked combinationally
//   addr            current beat address (drives haddr)
//   last_beat       the beat currently in its address phase is the final one
//   cmd_ok          command is legal: known burst, size fits bus, aligned,
//                   burst stays inside one 1 KB region
// ADDR_W must be at least 10 (the 1 KB check looks at cmd_addr[9:0]).
module ahb_addr_gen
  import ahb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [2:0]        cmd_burst,
  output logic [ADDR_W-1:0] addr,
  output logic              last_beat,
  output logic              cmd_ok
);

  logic [4:0]  beats, cnt;
  logic [2:0]  size_q;
  logic [11:0] bytes, span, end_off;
  logic [6:0]  mask;
  logic        size_ok, aligned, crosses;

  // 12 bits cover the worst case: 16 beats of 128 bytes plus a 1023 offset.
  always_comb begin
    beats   = burst_beats(cmd_burst);
    bytes   = 12'd1 << cmd_size;
    span    = {7'd0, beats} << cmd_size;
    end_off = {2'd0, cmd_addr[9:0]} + span;
    mask    = bytes[6:0] - 7'd1;
    size_ok = bytes <= 12'(DATA_W / 8);
    aligned = (cmd_addr[6:0] & mask) == 7'd0;
    crosses = end_off > 12'd1024;
    cmd_ok  = (beats != 5'd0) && size_ok && aligned && !crosses;
  end

  // Counter loads the beat count and reaches 0 after the final address phase.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      addr   <= '0;
      cnt    <= '0;
      size_q <= '0;
    end else if (load) begin
      addr   <= cmd_addr;
      cnt    <= beats;
      size_q <= cmd_size;
    end else if (step) begin
      addr <= addr + (ADDR_W'(1) << size_q);
      cnt  <= cnt - 5'd1;
    end
  end

  assign last_beat = (cnt == 5'd1);

endmodule

// File: rtl/ahb_burst_master.sv
// ahb_burst_master: AHB-Lite master issuing one SINGLE/INCR4/8/16 burst per
// local command, with pipelined address/data phases, wait states, two-cycle
// ERROR abort and 1 KB / alignment / size rejection.
//   hclk, hresetn           clock, async active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_addr/write/size/burst  command fields
//   wd_pop, wdata           write beat consumed in the cycle wd_pop is high
//   rd_valid, rd_data       read beat strobe and data
//   done, err               completion pulse; err marks rejection or ERROR
//   haddr..hwdata           AHB master outputs
//   hready, hresp, hrdata   AHB slave responses
module ahb_burst_master
  import ahb_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter int         ADDR_W    = 32,
  parameter logic [3:0] HPROT_DEF = 4'b0011
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [2:0]        cmd_burst,
  output logic              wd_pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic              hmastlock,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata
);

  state_t state, nstate;
  logic   load, step, last_beat, cmd_ok;
  logic   done_d, err_d, dphase, err_first;

  ahb_addr_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .load      (load),
    .step      (step),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_burst (cmd_burst),
    .addr      (haddr),
    .last_beat (last_beat),
    .cmd_ok    (cmd_ok)
  );

  assign cmd_ready = (state == S_IDLE);
  assign hprot     = HPROT_DEF;
  assign hmastlock = 1'b0;

  // A data phase is outstanding exactly in BURST (previous beat) and LAST.
  assign dphase    = (state == S_BURST) || (state == S_LAST);
  // First ERROR cycle: slave stalls with ERROR on the outstanding data phase.
  assign err_first = dphase && !hready && (hresp == HRESP_ERROR);

  assign wd_pop   = step && hwrite;
  assign rd_valid = dphase && !hwrite && hready && (hresp == HRESP_OKAY);
  assign rd_data  = rd_valid ? hrdata : '0;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= S_IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    htrans = HTRANS_IDLE;
    load   = 1'b0;
    step   = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_ok) begin
            load   = 1'b1;
            nstate = S_ADDR;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      S_ADDR: begin
        htrans = HTRANS_NONSEQ;
        if (hready) begin
          step   = 1'b1;
          nstate = last_beat ? S_LAST : S_BURST;
        end
      end
      S_BURST: begin
        htrans = HTRANS_SEQ;
        if (err_first) begin
          nstate = S_ERR;
        end else if (hready) begin
          step   = 1'b1;
          nstate = last_beat ? S_LAST : S_BURST;
        end
      end
      S_LAST: begin
        if (err_first) begin
          nstate = S_ERR;
        end else if (hready) begin
          done_d = 1'b1;
          nstate = S_IDLE;
        end
      end
      S_ERR: begin
        // htrans IDLE here cancels the SEQ still pending on the bus.
        done_d = 1'b1;
        err_d  = 1'b1;
        nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      done   <= 1'b0;
      err    <= 1'b0;
      hwrite <= 1'b0;
      hsize  <= '0;
      hburst <= '0;
      hwdata <= '0;
    end else begin
      done <= done_d;
      err  <= err_d;
      if (load) begin
        hwrite <= cmd_write;
        hsize  <= cmd_size;
        hburst <= cmd_burst;
      end
      if (wd_pop) hwdata <= wdata;
    end
  end

endmodule

// File: tb/tb_ahb_burst_master.sv
// tb_ahb_burst_master: directed bench; each task drives one scenario and
// compares outputs against hand-computed values, sampling on the falling edge.
module tb_ahb_burst_master;
  import ahb_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  logic              hclk = 1'b0, hresetn = 1'b0;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [2:0]        cmd_size = '0, cmd_burst = '0;
  logic              wd_pop, rd_valid, done, err;
  logic [DATA_W-1:0] wdata = '0, rd_data, hwdata, hrdata = '0;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite, hmastlock, hready = 1'b1, hresp = 1'b0;
  logic [2:0]        hsize, hburst;
  logic [3:0]        hprot;

  int checks = 0, errors = 0;

  always #5 hclk = ~hclk;

  ahb_burst_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HPROT_DEF(4'b0011)) dut (
    .hclk(hclk), .hresetn(hresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_pop(wd_pop), .wdata(wdata), .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err(err), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
    .hwdata(hwdata), .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  // Caller is 1 ns after a rising edge; returns 1 ns after the accepting edge T.
  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] s,
                       input logic [2:0] b);
    cmd_addr = a; cmd_write = w; cmd_size = s; cmd_burst = b; cmd_valid = 1'b1;
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge hclk);
    checks++; if (haddr !== 32'h0) begin errors++; $display("FAIL rst_haddr got %h want 0", haddr); end
    checks++; if (htrans !== HTRANS_IDLE) begin errors++; $display("FAIL rst_htrans got %b want 00", htrans); end
    checks++; if ({hwrite, hsize, hburst} !== 7'b0) begin errors++; $display("FAIL rst_ctrl got %b want 0", {hwrite, hsize, hburst}); end
    checks++; if (hwdata !== 32'h0 || rd_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h/%h want 0", hwdata, rd_data); end
    checks++; if ({done, err, rd_valid, wd_pop, hmastlock} !== 5'b0) begin errors++; $display("FAIL rst_strobes got %b want 0", {done, err, rd_valid, wd_pop, hmastlock}); end
    checks++; if (hprot !== 4'b0011) begin errors++; $display("FAIL rst_hprot got %b want 0011", hprot); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", cmd_ready); end
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;
  endtask

  task automatic test_single_read;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'hDEADBEEF;
    issue(32'h100, 1'b0, 3'd2, HBURST_SINGLE);
    @(negedge hclk);
    checks++; if (htrans !== HTRANS_NONSEQ || haddr !== 32'h100) begin errors++; $display("FAIL sr_addr got %b/%h want 10/100", htrans, haddr); end
    checks++; if ({hwrite, hsize, hburst} !== {1'b0, 3'd2, HBURST_SINGLE}) begin errors++; $display("FAIL sr_ctrl got %b want 0010000", {hwrite, hsize, hburst}); end
    checks++; if (cmd_ready !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL sr_busy got ready %b rdv %b want 0 0", cmd_ready, rd_valid); end
    @(posedge hclk); #1; @(negedge hclk);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rdata got %b/%h want 1/deadbeef", rd_valid, rd_data); end
    checks++; if (htrans !== HTRANS_IDLE || done !== 1'b0) begin errors++; $display("FAIL sr_last got %b/%b want 00/0", htrans, done); end
    @(posedge hclk); #1; @(negedge hclk);
    checks++; if (done !== 1'b1 || err !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL sr_done got %b%b%b want 100", done, err, rd_valid); end
    @(posedge hclk); #1; @(negedge hclk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL sr_done_pulse got %b want 0", done); end
    @(posedge hclk); #1;
  endtask

  task automatic test_incr4_write(input logic [31:0] base);
    logic [1:0] et;
    issue(base, 1'b1, 3'd2, HBURST_INCR4);
    for (int k = 1; k <= 6; k++) begin
      wdata = 32'(k);
      @(negedge hclk);
      et = (k == 1) ? HTRANS_NONSEQ : (k <= 4) ? HTRANS_SEQ : HTRANS_IDLE;
      checks++; if (htrans !== et) begin errors++; $display("FAIL w4_htrans k=%0d got %b want %b", k, htrans, et); end
      if (k <= 4) begin
        checks++; if (haddr !== base + 32'(4 * (k - 1))) begin errors++; $display("FAIL w4_haddr k=%0d got %h want %h", k, haddr, base + 32'(4 * (k - 1))); end
      end
      checks++; if (wd_pop !== (k <= 4)) begin errors++; $display("FAIL w4_pop k=%0d got %b", k, wd_pop); end
      if (k >= 2 && k <= 5) begin
        checks++; if (hwdata !== 32'(k - 1)) begin errors++; $display("FAIL w4_hwdata k=%0d got %h want %h", k, hwdata, 32'(k - 1)); end
      end
      checks++; if (done !== (k == 6) || err !== 1'b0) begin errors++; $display("FAIL w4_done k=%0d got %b%b", k, done, err); end
      @(posedge hclk); #1;
    end
  endtask

  task automatic test_incr8_wait;
    int rd_cnt = 0;
    int beat;
    logic exp_rd;
    issue(32'h0, 1'b0, 3'd2, HBURST_INCR8);
    for (int k = 1; k <= 12; k++) begin
      hready = !(k == 4 || k == 5);
      hrdata = 32'hC0DE0000 + 32'(k);
      @(negedge hclk);
      beat   = (k <= 3) ? k : (k <= 6) ? 4 : k - 2;
      exp_rd = (k == 2 || k == 3 || (k >= 6 && k <= 11));
      if (k <= 10) begin
        checks++; if (haddr !== 32'(4 * (beat - 1))) begin errors++; $display("FAIL r8_haddr k=%0d got %h want %h", k, haddr, 32'(4 * (beat - 1))); end
        checks++; if (htrans !== ((k == 1) ? HTRANS_NONSEQ : HTRANS_SEQ)) begin errors++; $display("FAIL r8_htrans k=%0d got %b", k, htrans); end
      end
      checks++; if (rd_valid !== exp_rd) begin errors++; $display("FAIL r8_rdv k=%0d got %b want %b", k, rd_valid, exp_rd); end
      if (exp_rd) begin
        checks++; if (rd_data !== 32'hC0DE0000 + 32'(k)) begin errors++; $display("FAIL r8_rdata k=%0d got %h want %h", k, rd_data, 32'hC0DE0000 + 32'(k)); end
      end
      if (rd_valid === 1'b1) rd_cnt++;
      checks++; if (done !== (k == 12)) begin errors++; $display("FAIL r8_done k=%0d got %b", k, done); end
      @(posedge hclk); #1;
    end
    hready = 1'b1;
    checks++; if (rd_cnt != 8) begin errors++; $display("FAIL r8_count got %0d want 8", rd_cnt); end
  endtask

  task automatic test_cross_1k;
    issue(32'h3F0, 1'b1, 3'd2, HBURST_INCR16);
    @(negedge hclk);
    checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL x1k_doneerr got %b%b want 11", done, err); end
    checks++; if (htrans !== HTRANS_IDLE || wd_pop !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL x1k_idle got %b %b %b want 00 0 1", htrans, wd_pop, cmd_ready); end
    @(posedge hclk); #1;
    // Ends exactly on the boundary: legal.
    test_incr4_write(32'h3F0);
  endtask

  task automatic test_reject;
    logic [31:0] ra [3] = '{32'h0, 32'h0, 32'h102};
    logic [2:0]  rs [3] = '{3'd3, 3'd2, 3'd2};
    logic [2:0]  rb [3] = '{HBURST_SINGLE, 3'b001, HBURST_INCR4};
    for (int i = 0; i < 3; i++) begin
      issue(ra[i], 1'b0, rs[i], rb[i]);
      @(negedge hclk);
      checks++; if (done !== 1'b1 || err !== 1'b1 || htrans !== HTRANS_IDLE) begin errors++; $display("FAIL rej%0d got %b%b %b want 11 00", i, done, err, htrans); end
      @(posedge hclk); #1; @(negedge hclk);
      checks++; if (done !== 1'b0 || htrans !== HTRANS_IDLE) begin errors++; $display("FAIL rej%0d_after got %b %b want 0 00", i, done, htrans); end
      @(posedge hclk); #1;
    end
  endtask

  task automatic test_error;
    int rd_cnt = 0;
    issue(32'h40, 1'b0, 3'd2, HBURST_INCR4);
    hrdata = 32'h11112222;
    for (int k = 1; k <= 5; k++) begin
      hready = (k != 3);
      hresp  = (k == 3 || k == 4);
      @(negedge hclk);
      if (rd_valid === 1'b1) rd_cnt++;
      if (k == 3) begin
        checks++; if (htrans !== HTRANS_SEQ) begin errors++; $display("FAIL er_first got %b want 11", htrans); end
      end
      if (k == 4) begin
        checks++; if (htrans !== HTRANS_IDLE || wd_pop !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL er_second got %b %b %b want 00 0 0", htrans, wd_pop, done); end
      end
      if (k == 5) begin
        checks++; if (done !== 1'b1 || err !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL er_done got %b%b%b want 111", done, err, cmd_ready); end
      end
      @(posedge hclk); #1;
    end
    hready = 1'b1; hresp = 1'b0;
    checks++; if (rd_cnt != 1) begin errors++; $display("FAIL er_rdcount got %0d want 1", rd_cnt); end
  endtask

  task automatic test_back_to_back;
    wdata = 32'hAAAA5555;
    issue(32'h10, 1'b1, 3'd2, HBURST_SINGLE);
    // Held high while busy: must only be taken once cmd_ready returns.
    cmd_valid = 1'b1; cmd_addr = 32'h20;
    @(negedge hclk);
    checks++; if (htrans !== HTRANS_NONSEQ || haddr !== 32'h10 || wd_pop !== 1'b1) begin errors++; $display("FAIL bb_first got %b %h %b want 10 10 1", htrans, haddr, wd_pop); end
    @(posedge hclk); #1; @(negedge hclk);
    checks++; if (htrans !== HTRANS_IDLE || hwdata !== 32'hAAAA5555) begin errors++; $display("FAIL bb_data got %b %h want 00 aaaa5555", htrans, hwdata); end
    @(posedge hclk); #1; @(negedge hclk);
    checks++; if (done !== 1'b1 || htrans !== HTRANS_IDLE || cmd_ready !== 1'b1) begin errors++; $display("FAIL bb_gap got %b %b %b want 1 00 1", done, htrans, cmd_ready); end
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
    @(negedge hclk);
    checks++; if (htrans !== HTRANS_NONSEQ || haddr !== 32'h20) begin errors++; $display("FAIL bb_second got %b %h want 10 20", htrans, haddr); end
    @(posedge hclk); #1; @(posedge hclk); #1; @(negedge hclk);
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL bb_done got %b%b want 10", done, err); end
    @(posedge hclk); #1;
  endtask

  task automatic test_reset_mid;
    int dn = 0;
    wdata = 32'h5A5A5A5A;
    issue(32'h80, 1'b1, 3'd2, HBURST_INCR4);
    @(posedge hclk); #1; @(posedge hclk); #1;
    hresetn = 1'b0;
    #1;
    checks++; if (htrans !== HTRANS_IDLE || haddr !== 32'h0 || hwdata !== 32'h0 || wd_pop !== 1'b0) begin errors++; $display("FAIL rm_async got %b %h %h %b want 00 0 0 0", htrans, haddr, hwdata, wd_pop); end
    @(posedge hclk); #1;
    hresetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge hclk);
      if (done === 1'b1 || htrans !== HTRANS_IDLE) dn++;
      @(posedge hclk); #1;
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL rm_quiet got %0d busy/done cycles want 0", dn); end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_incr4_write(32'h200);
    test_incr8_wait;
    test_cross_1k;
    test_reject;
    test_error;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_burst_master.md
# ahb_burst_master

Parametrised AHB-Lite bus master that turns a single local command into a SINGLE or fixed-length INCR burst (INCR4/8/16) with correctly pipelined address and data phases. It adds wait-state handling, two-cycle ERROR response with burst abort, byte/halfword/word transfer sizes and 1 KB boundary protection. It sits between a local request engine and the AHB-Lite interconnect.

## Interface
- DATA_W, 32, bus data width (32 or 64)
- ADDR_W, 32, bus address width
- HPROT_DEF, 4'b0011, constant value driven on hprot
- hclk  in  1  bus clock, all logic on rising edge
- hresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high while in IDLE; command accepted when cmd_valid & cmd_ready
- cmd_addr  in  ADDR_W  start byte address
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  3  AHB HSIZE encoding
- cmd_burst  in  3  000 SINGLE, 011 INCR4, 101 INCR8, 111 INCR16; other codes rejected
- wd_pop  out  1  one-cycle strobe: wdata consumed this cycle
- wdata  in  DATA_W  next write beat, valid whenever wd_pop is high
- rd_valid  out  1  one-cycle strobe: rd_data holds a read beat
- rd_data  out  DATA_W  read beat
- done  out  1  one-cycle pulse at command completion or abort
- err  out  1  one-cycle pulse together with done on rejection or ERROR response
- haddr, htrans[1:0], hwrite, hsize[2:0], hburst[2:0], hprot[3:0], hmastlock, hwdata[DATA_W]  out  AHB master signals
- hready  in  1  bus ready
- hresp  in  1  0 OKAY, 1 ERROR
- hrdata  in  DATA_W  read data

## Operation
- States: IDLE, ADDR (first beat, htrans NONSEQ), BURST (beats 2..N, htrans SEQ), LAST (data phase of final beat, htrans IDLE), ERR (second ERROR cycle).
- Reset: state IDLE; haddr 0, htrans IDLE, hwrite 0, hsize 0, hburst 0, hwdata 0, rd_data 0, all strobes 0, hmastlock 0 (never asserted), hprot = HPROT_DEF.
- Acceptance check: reject if cmd_burst is not a listed code, if 2^cmd_size > DATA_W/8, if cmd_addr is not size-aligned, or if the burst crosses a 1 KB boundary (cmd_addr[9:0] + beats·2^size > 1024). A rejected command causes no bus activity. done and err pulse in the cycle after acceptance. State returns to IDLE.
- Beat address: haddr increments by 2^cmd_size after each completed address phase. Beat counter runs from the beat count (1/4/8/16) down to 0.
- Address phase completes on hready=1. The next beat's address is presented together with the previous beat's data phase.
- Write: wd_pop is high in the cycle a write address phase completes. wdata is registered into hwdata for the following data phase.
- Read: when a data phase completes with hready=1 and hresp=0, rd_valid pulses with rd_data = hrdata.
- ERROR response: the first cycle is hready=0, hresp=1. In the next cycle the master drives htrans IDLE (ERR state), cancelling the pending address. No further wd_pop or rd_valid for that command. done and err pulse; state returns to IDLE.
- Normal completion: done pulses in the cycle after the last data phase completes. err stays 0.

## Timing
- Command accepted at edge T. haddr/htrans NONSEQ/hburst/hsize/hwrite are valid from T+1.
- Zero-wait INCR4 write: NONSEQ at T+1, SEQ at T+2..T+4, last data at T+5, done at T+6. Best-case latency is N+2 cycles.
- Each hready=0 cycle holds all address and data outputs stable and extends latency by 1.
- htrans is never BUSY. Between commands htrans is IDLE for at least one cycle.
- Reset asserted mid-burst forces the reset values immediately. No done pulse is generated.
- A command presented while cmd_ready=0 is ignored.

## Structure
- Shared package ahb_pkg: HTRANS_* and HBURST_* constants, HRESP codes, state encoding, and a burst-to-beat-count function.
- Sub-module ahb_addr_gen: holds the beat counter, address incrementer and 1 KB/alignment check. The top level keeps the FSM and the data path.

## Test plan
- SINGLE read at 0x100, size 2, hrdata=0xDEADBEEF, no waits -> one NONSEQ; rd_valid with 0xDEADBEEF at T+2; done at T+3.
- INCR4 write at 0x200, size 2, wdata 1..4 -> haddr 0x200/204/208/20C; hwdata 1..4 one cycle after each address; done at T+6.
- INCR8 read with hready=0 for 2 cycles on beat 3 -> outputs held; 8 rd_valid strobes; done at T+12.
- INCR16 write, size 2, at 0x3F0 -> crosses 1 KB; no htrans activity; done=err=1 at T+1.
- INCR4 read with ERROR on beat 2 -> htrans IDLE on the second ERROR cycle; exactly 1 rd_valid; done=err=1.
- Size 3 with DATA_W=32, or cmd_burst=001 -> rejected; err pulse; bus stays idle.
